tx_width_conv_fifo: RTL and testbench
=====================================

Name: tx_width_conv_fifo

Overview:
- Single-clock (synchronous) FIFO with asymmetric port widths on the transmit path.
- Accepts 128-bit words on the write side and delivers 8-bit bytes on the read side, least-significant byte first.
- Capacity: 256 words = 4096 bytes.
- Provides full, empty, almost_full and almost_empty status to the producer and consumer.

Parameters:
- WR_DEPTH_WIDTH, 8, log2 of write-side depth in words (256).
- WR_DATA_WIDTH, 128, write word width.
- RD_DEPTH_WIDTH, 12, log2 of read-side depth in bytes (4096).
- RD_DATA_WIDTH, 8, read word width.
- ALMOST_FULL_NUM, 15, write-side word count at or above which almost_full asserts.
- ALMOST_EMPTY_NUM, 4, read-side byte count at or below which almost_empty asserts.
- Legal sets: WR_DATA_WIDTH*2^WR_DEPTH_WIDTH == RD_DATA_WIDTH*2^RD_DEPTH_WIDTH; WR_DATA_WIDTH/RD_DATA_WIDTH is a power of two (16 by default).

Ports:
- clk  in  1  clock; all logic on rising edge.
- tb_rst  in  1  reset tb_rst, asynchronous, active-high; clock clk.
- wr_data  in  128  write word.
- wr_en  in  1  write request.
- wr_full  out  1  FIFO holds 256 words' worth of unread data.
- almost_full  out  1  write-side word count >= ALMOST_FULL_NUM.
- rd_data  out  8  read byte.
- rd_en  in  1  read request.
- rd_empty  out  1  no unread bytes.
- almost_empty  out  1  read-side byte count <= ALMOST_EMPTY_NUM.

Behaviour:
- Storage: 256 x 128-bit memory. Pointers:
  - wptr: 9 bits, counts words.
  - rptr: 13 bits, counts bytes; word index = rptr[12:4], byte select = rptr[3:0].
- Counts:
  - rd_count = {wptr,4'b0} - rptr (0..4096).
  - wr_count = wptr - rptr[12:4] (0..256); a word slot is freed only after all 16 of its bytes are read.
- Write: on posedge clk with wr_en=1 and wr_full=0, store wr_data at wptr[7:0]; wptr+1.
- Write while full: ignored; no pointer or data change.
- Read: on posedge clk with rd_en=1 and rd_empty=0, rd_data <= byte rptr[3:0] of word rptr[11:4] (byte 0 = bits [7:0] first, byte 15 = bits [127:120] last); rptr+1.
  - Read latency: data valid the cycle after the accepting edge. No extra output register, no output clock enable.
- Read while empty: ignored; rd_data holds its previous value.
- Flags are registered and reflect the counts after the current edge's accepted operations:
  - wr_full = (wr_count == 256).
  - rd_empty = (rd_count == 0).
  - almost_full = (wr_count >= ALMOST_FULL_NUM).
  - almost_empty = (rd_count <= ALMOST_EMPTY_NUM).
- First-write timing: rd_empty deasserts on the edge after the first write is accepted, i.e. a write at edge N makes 16 bytes readable from edge N+1.
- Simultaneous wr_en and rd_en: both accepted if their individual conditions hold; counts update by +16 bytes and -1 byte in the same cycle.
  - Read of the last byte while full frees one slot next cycle. The write in that same cycle is still blocked by the old wr_full.
- Wrap-around: pointers carry one extra MSB for full/empty disambiguation; memory index wraps modulo depth.
- Reset (tb_rst high, any time, including mid-transfer): wptr=0, rptr=0, rd_data=0, wr_full=0, almost_full=0, rd_empty=1, almost_empty=1. Memory contents are not cleared. Operations resume the first edge after release.
- No dependency on any global reset/set primitive. The design operates correctly with the device global reset inactive (GRS_N tied high).

Test Plan:
- Reset: hold tb_rst 200 ns -> rd_empty=1, almost_empty=1, wr_full=0, almost_full=0, rd_data=0.
- Fill:
  - Stimulus: 257 consecutive writes of decrementing counter starting 128'hFF..FF.
  - almost_full rises after the 15th accepted write.
  - wr_full rises after the 256th.
  - The 257th write is ignored (wptr stays 256).
- Drain:
  - Stimulus: 4097 consecutive reads.
  - Bytes appear one cycle after each read: 16 x 8'hFF (word 0), then FE, FF x15 (word 1, LSB first), etc.
  - wr_full drops after the 16th read; almost_empty asserts once rd_count <= 4; rd_empty after the 4096th read.
  - The 4097th read is ignored and rd_data holds.
- Byte order: write 128'h0F0E0D0C0B0A09080706050403020100 into an empty FIFO, read 16 -> 8'h00,01,...,0F in order.
- Concurrent: from the half-full state, assert wr_en and rd_en every cycle for 64 cycles -> no data loss or duplication; rd_count rises by 15 per cycle; the byte sequence stays contiguous.
- Mid-operation reset: after 10 writes and 5 reads, pulse tb_rst -> all flags and rd_data return to reset values. A subsequent write of 128'h...01 reads back 8'h01 first.

Source files
------------

// File: rtl/tx_width_conv_fifo_if.sv
// Handshake bundle for tx_width_conv_fifo.
//   master: producer/consumer side (drives wr_data, wr_en, rd_en)
//   slave : FIFO side (drives wr_full, almost_full, rd_data, rd_empty, almost_empty)
interface tx_width_conv_fifo_if #(
  parameter int WR_DATA_WIDTH = 128,
  parameter int RD_DATA_WIDTH = 8
);
  logic [WR_DATA_WIDTH-1:0] wr_data;
  logic                     wr_en;
  logic                     wr_full;
  logic                     almost_full;
  logic [RD_DATA_WIDTH-1:0] rd_data;
  logic                     rd_en;
  logic                     rd_empty;
  logic                     almost_empty;

  modport master (
    output wr_data, wr_en, rd_en,
    input  wr_full, almost_full, rd_data, rd_empty, almost_empty
  );

  modport slave (
    input  wr_data, wr_en, rd_en,
    output wr_full, almost_full, rd_data, rd_empty, almost_empty
  );
endinterface

// File: rtl/tx_width_conv_fifo.sv
// Single-clock width-converting FIFO: wide words in, narrow bytes out,
// least-significant slice first. Storage is 2^WR_DEPTH_WIDTH wide words.
// Ports:
//   clk          rising-edge clock
//   tb_rst       asynchronous active-high reset
//   bus (slave)  wr_data/wr_en/wr_full/almost_full  - write side
//                rd_data/rd_en/rd_empty/almost_empty - read side
// All status flags are registered and reflect the occupancy after the
// operations accepted on the current edge. rd_data is valid the cycle after
// the accepting edge and holds otherwise.
// Legal parameter sets: WR_DATA_WIDTH*2^WR_DEPTH_WIDTH ==
// RD_DATA_WIDTH*2^RD_DEPTH_WIDTH, and the width ratio is a power of two.
module tx_width_conv_fifo #(
  parameter int WR_DEPTH_WIDTH   = 8,
  parameter int WR_DATA_WIDTH    = 128,
  parameter int RD_DEPTH_WIDTH   = 12,
  parameter int RD_DATA_WIDTH    = 8,
  parameter int ALMOST_FULL_NUM  = 15,
  parameter int ALMOST_EMPTY_NUM = 4
) (
  input logic                 clk,
  input logic                 tb_rst,
  tx_width_conv_fifo_if.slave bus
);
  localparam int SEL_W = RD_DEPTH_WIDTH - WR_DEPTH_WIDTH;  // slice-select bits
  localparam int RATIO = 1 << SEL_W;                      // slices per word
  localparam int WPW   = WR_DEPTH_WIDTH + 1;
  localparam int RPW   = RD_DEPTH_WIDTH + 1;

  localparam logic [WPW-1:0] WR_FULL_CNT = {1'b1, {WR_DEPTH_WIDTH{1'b0}}};
  localparam logic [WPW-1:0] AF_TH       = ALMOST_FULL_NUM[WPW-1:0];
  localparam logic [RPW-1:0] AE_TH       = ALMOST_EMPTY_NUM[RPW-1:0];

  logic [WR_DATA_WIDTH-1:0] mem [2**WR_DEPTH_WIDTH];

  // Pointers carry one extra MSB so full and empty are distinguishable.
  logic [WPW-1:0] wptr, wptr_nxt;
  logic [RPW-1:0] rptr, rptr_nxt;
  logic [WPW-1:0] wr_count_nxt;
  logic [RPW-1:0] rd_count_nxt;
  logic           wr_acc, rd_acc;

  logic                     wr_full_q, almost_full_q, rd_empty_q, almost_empty_q;
  logic [RD_DATA_WIDTH-1:0] rd_q;
  logic [RATIO-1:0][RD_DATA_WIDTH-1:0] rd_word;

  // Acceptance uses the registered flags, so a write in the same cycle as
  // the read that frees a slot is still refused.
  assign wr_acc = bus.wr_en & ~wr_full_q;
  assign rd_acc = bus.rd_en & ~rd_empty_q;

  assign wptr_nxt = wptr + {{WR_DEPTH_WIDTH{1'b0}}, wr_acc};
  assign rptr_nxt = rptr + {{RD_DEPTH_WIDTH{1'b0}}, rd_acc};

  // Byte occupancy; word occupancy only releases a slot once its last
  // slice has been read (truncating rptr to a word index).
  assign rd_count_nxt = {wptr_nxt, {SEL_W{1'b0}}} - rptr_nxt;
  assign wr_count_nxt = wptr_nxt - rptr_nxt[RPW-1:SEL_W];

  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      wptr           <= '0;
      rptr           <= '0;
      wr_full_q      <= 1'b0;
      almost_full_q  <= 1'b0;
      rd_empty_q     <= 1'b1;
      almost_empty_q <= 1'b1;
    end else begin
      wptr           <= wptr_nxt;
      rptr           <= rptr_nxt;
      wr_full_q      <= (wr_count_nxt == WR_FULL_CNT);
      almost_full_q  <= (wr_count_nxt >= AF_TH);
      rd_empty_q     <= (rd_count_nxt == '0);
      almost_empty_q <= (rd_count_nxt <= AE_TH);
    end
  end

  // Storage has no reset; contents survive tb_rst.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wptr[WR_DEPTH_WIDTH-1:0]] <= bus.wr_data;
  end

  // Reading a word that is being written cannot happen: a readable word is
  // never the write target unless the FIFO is full, and then writes stall.
  assign rd_word = mem[rptr[RD_DEPTH_WIDTH-1:SEL_W]];

  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst)      rd_q <= '0;
    else if (rd_acc) rd_q <= rd_word[rptr[SEL_W-1:0]];
  end

  assign bus.wr_full      = wr_full_q;
  assign bus.almost_full  = almost_full_q;
  assign bus.rd_empty     = rd_empty_q;
  assign bus.almost_empty = almost_empty_q;
  assign bus.rd_data      = rd_q;
endmodule

// File: tb/tb_tx_width_conv_fifo.sv
// Bench for tx_width_conv_fifo: directed phases plus randomized traffic,
// with a byte-queue reference model compared on every falling edge.
module tb_tx_width_conv_fifo;
  logic clk    = 1'b0;
  logic tb_rst = 1'b1;
  always #5 clk = ~clk;

  tx_width_conv_fifo_if #(.WR_DATA_WIDTH(128), .RD_DATA_WIDTH(8)) bus ();

  tx_width_conv_fifo dut (
    .clk    (clk),
    .tb_rst (tb_rst),
    .bus    (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: unread bytes in a queue, plus how many bytes of the
  // head word have already been consumed (that word still holds a slot).
  byte unsigned mq[$];
  int           m_off   = 0;
  logic [7:0]   m_rd    = 8'h00;
  bit           m_full  = 1'b0;
  bit           m_af    = 1'b0;
  bit           m_empty = 1'b1;
  bit           m_ae    = 1'b1;
  bit           m_wa, m_ra;

  function automatic void m_flags();
    int words;
    words   = (mq.size() + m_off) / 16;
    m_full  = (words == 256);
    m_af    = (words >= 15);
    m_empty = (mq.size() == 0);
    m_ae    = (mq.size() <= 4);
  endfunction

  always @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      mq.delete();
      m_off = 0;
      m_rd  = 8'h00;
      m_flags();
    end else begin
      m_wa = bus.wr_en && !m_full;
      m_ra = bus.rd_en && !m_empty;
      if (m_ra) begin
        m_rd  = mq.pop_front();
        m_off = (m_off + 1) % 16;
      end
      if (m_wa)
        for (int i = 0; i < 16; i++) mq.push_back(bus.wr_data[i*8 +: 8]);
      m_flags();
    end
  end

  always @(negedge clk) begin
    chk("rd_data",      {120'd0, bus.rd_data},      {120'd0, m_rd});
    chk("wr_full",      {127'd0, bus.wr_full},      {127'd0, m_full});
    chk("almost_full",  {127'd0, bus.almost_full},  {127'd0, m_af});
    chk("rd_empty",     {127'd0, bus.rd_empty},     {127'd0, m_empty});
    chk("almost_empty", {127'd0, bus.almost_empty}, {127'd0, m_ae});
  end

  // One clock: drive inputs now (just after an edge), return 1 ns after the
  // next rising edge so registered outputs can be inspected.
  task automatic cyc(input bit we, input bit re, input logic [127:0] d);
    bus.wr_en   = we;
    bus.rd_en   = re;
    bus.wr_data = d;
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  logic [127:0] d;
  int           pw, pr;

  initial begin
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.wr_data = '0;
    #200;
    @(posedge clk);
    #1;
    tb_rst = 1'b0;

    // Reset state
    chk("rst_rd_empty",     {127'd0, bus.rd_empty},     128'd1);
    chk("rst_almost_empty", {127'd0, bus.almost_empty}, 128'd1);
    chk("rst_wr_full",      {127'd0, bus.wr_full},      128'd0);
    chk("rst_almost_full",  {127'd0, bus.almost_full},  128'd0);
    chk("rst_rd_data",      {120'd0, bus.rd_data},      128'd0);

    // Fill with a decrementing counter, one write past full
    d = '1;
    for (int k = 1; k <= 257; k++) begin
      cyc(1'b1, 1'b0, d);
      d = d - 1'b1;
      if (k == 1)   chk("fill_first_not_empty", {127'd0, bus.rd_empty},    128'd0);
      if (k == 14)  chk("fill_af_14",           {127'd0, bus.almost_full}, 128'd0);
      if (k == 15)  chk("fill_af_15",           {127'd0, bus.almost_full}, 128'd1);
      if (k == 255) chk("fill_full_255",        {127'd0, bus.wr_full},     128'd0);
      if (k == 256) chk("fill_full_256",        {127'd0, bus.wr_full},     128'd1);
    end
    chk("fill_bytes_held", 128'(mq.size()), 128'd4096);

    // Drain, one read past empty
    for (int k = 1; k <= 4097; k++) begin
      cyc(1'b0, 1'b1, '0);
      if (k == 1)    chk("drain_b1",        {120'd0, bus.rd_data},      128'hFF);
      if (k == 15)   chk("drain_full_15",   {127'd0, bus.wr_full},      128'd1);
      if (k == 16)   chk("drain_full_16",   {127'd0, bus.wr_full},      128'd0);
      if (k == 17)   chk("drain_b17",       {120'd0, bus.rd_data},      128'hFE);
      if (k == 18)   chk("drain_b18",       {120'd0, bus.rd_data},      128'hFF);
      if (k == 4091) chk("drain_ae_4091",   {127'd0, bus.almost_empty}, 128'd0);
      if (k == 4092) chk("drain_ae_4092",   {127'd0, bus.almost_empty}, 128'd1);
      if (k == 4095) chk("drain_empty_4095",{127'd0, bus.rd_empty},     128'd0);
      if (k == 4096) chk("drain_empty_4096",{127'd0, bus.rd_empty},     128'd1);
      if (k == 4097) chk("drain_hold",      {120'd0, bus.rd_data},      128'hFF);
    end

    // Byte order
    cyc(1'b1, 1'b0, 128'h0F0E0D0C0B0A09080706050403020100);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 1'b1, '0);
      chk("order_byte", {120'd0, bus.rd_data}, 128'(i));
    end
    chk("order_empty", {127'd0, bus.rd_empty}, 128'd1);

    // Half full, then simultaneous read/write for 64 cycles
    for (int i = 0; i < 128; i++) cyc(1'b1, 1'b0, rnd128());
    for (int i = 0; i < 64; i++) cyc(1'b1, 1'b1, rnd128());
    chk("conc_bytes", 128'(mq.size()), 128'd3008);
    chk("conc_af",    {127'd0, bus.almost_full}, 128'd1);

    // Mid-operation reset
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, rnd128());
    for (int i = 0; i < 5; i++)  cyc(1'b0, 1'b1, '0);
    tb_rst = 1'b1;
    #3;
    tb_rst = 1'b0;
    chk("mrst_rd_empty",     {127'd0, bus.rd_empty},     128'd1);
    chk("mrst_almost_empty", {127'd0, bus.almost_empty}, 128'd1);
    chk("mrst_wr_full",      {127'd0, bus.wr_full},      128'd0);
    chk("mrst_almost_full",  {127'd0, bus.almost_full},  128'd0);
    chk("mrst_rd_data",      {120'd0, bus.rd_data},      128'd0);
    cyc(1'b1, 1'b0, 128'h01);
    cyc(1'b0, 1'b1, '0);
    chk("mrst_first_byte", {120'd0, bus.rd_data}, 128'h01);

    // Random traffic: fill-biased, drain-biased, then hover near empty
    for (int c = 0; c < 7300; c++) begin
      if (c < 800)       begin pw = 70; pr = 50; end
      else if (c < 6800) begin pw = 1;  pr = 95; end
      else               begin pw = 5;  pr = 90; end
      cyc($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr, rnd128());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
